// File: rtl/acumulador_productos_if.sv
// Valid/ready bundle between the multiplier and the product accumulator.
// The master drives products and consumes results; the slave is the accumulator.
interface acumulador_productos_if #(
    parameter int ANCHO_PROD   = 16,
    parameter int ANCHO_CUENTA = 3
);
    logic signed [ANCHO_PROD-1:0] producto;
    logic                         producto_valido;
    logic                         listo;
    logic signed [15:0]           salida;
    logic                         salida_valida;
    logic                         salida_tomada;
    logic                         saturado;
    logic [ANCHO_CUENTA-1:0]      cuenta;

    modport master (
        output producto, producto_valido, salida_tomada,
        input  listo, salida, salida_valida, saturado, cuenta
    );

    modport slave (
        input  producto, producto_valido, salida_tomada,
        output listo, salida, salida_valida, saturado, cuenta
    );
endinterface

// File: rtl/acumulador_productos.sv
// Windowed MAC back-end: sums N_MUESTRAS signed products, shifts, saturates to 16 bits.
// Optional round-half-up before the shift when ACUM_REDONDEO_EN is defined.
module acumulador_productos #(
    parameter int ANCHO_PROD = 16,
    parameter int ANCHO_ACC  = 24,
    parameter int N_MUESTRAS = 4,
    parameter int DESPLAZA   = 0
) (
    input logic clk,
    input logic reset,
    acumulador_productos_if.slave bus
);
    localparam int CW = $clog2(N_MUESTRAS + 1);
    localparam logic [CW-1:0] ULTIMA = CW'(N_MUESTRAS - 1);
    localparam logic signed [ANCHO_ACC:0] MAXV = (ANCHO_ACC + 1)'(32767);
    localparam logic signed [ANCHO_ACC:0] MINV = (ANCHO_ACC + 1)'(-32768);

    typedef enum logic {
        ACUMULA = 1'b0,
        ENTREGA = 1'b1
    } estado_t;

    estado_t                     r_estado, w_estado_sig;
    logic signed [ANCHO_ACC-1:0] r_acc, w_acc_sig, w_suma;
    logic signed [ANCHO_ACC:0]   w_ext, w_t;
    logic [CW-1:0]               r_cuenta, w_cuenta_sig;
    logic signed [15:0]          r_salida, w_salida_sig, w_sal_calc;
    logic                        r_valida, w_valida_sig;
    logic                        r_sat, w_sat_sig, w_sat_calc;

    assign w_suma = r_acc + ANCHO_ACC'(bus.producto);
    assign w_ext  = (ANCHO_ACC + 1)'(w_suma);

    // One extra bit keeps the rounding add from overflowing
`ifdef ACUM_REDONDEO_EN
    generate
        if (DESPLAZA > 0) begin : g_redondeo
            localparam logic signed [ANCHO_ACC:0] MEDIO =
                (ANCHO_ACC + 1)'(1) << (DESPLAZA - 1);
            assign w_t = (w_ext + MEDIO) >>> DESPLAZA;
        end else begin : g_trunc
            assign w_t = w_ext >>> DESPLAZA;
        end
    endgenerate
`else
    assign w_t = w_ext >>> DESPLAZA;
`endif

    always_comb begin
        w_sal_calc = w_t[15:0];
        w_sat_calc = 1'b0;
        if (w_t > MAXV) begin
            w_sal_calc = 16'sh7fff;
            w_sat_calc = 1'b1;
        end else if (w_t < MINV) begin
            w_sal_calc = 16'sh8000;
            w_sat_calc = 1'b1;
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        w_acc_sig    = r_acc;
        w_cuenta_sig = r_cuenta;
        w_salida_sig = r_salida;
        w_sat_sig    = r_sat;
        w_valida_sig = r_valida;
        unique case (r_estado)
            ACUMULA: begin
                if (bus.producto_valido) begin
                    w_acc_sig    = w_suma;
                    w_cuenta_sig = r_cuenta + 1'b1;
                    if (r_cuenta == ULTIMA) begin
                        w_salida_sig = w_sal_calc;
                        w_sat_sig    = w_sat_calc;
                        w_valida_sig = 1'b1;
                        w_estado_sig = ENTREGA;
                    end
                end
            end
            ENTREGA: begin
                if (bus.salida_tomada) begin
                    w_valida_sig = 1'b0;
                    w_acc_sig    = '0;
                    w_cuenta_sig = '0;
                    w_estado_sig = ACUMULA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_estado <= ACUMULA;
        else       r_estado <= w_estado_sig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_cuenta <= '0;
            r_salida <= '0;
            r_sat    <= 1'b0;
            r_valida <= 1'b0;
        end else begin
            r_acc    <= w_acc_sig;
            r_cuenta <= w_cuenta_sig;
            r_salida <= w_salida_sig;
            r_sat    <= w_sat_sig;
            r_valida <= w_valida_sig;
        end
    end

    assign bus.listo         = (r_estado == ACUMULA) && !reset;
    assign bus.salida        = r_salida;
    assign bus.salida_valida = r_valida;
    assign bus.saturado      = r_sat;
    assign bus.cuenta        = r_cuenta;
endmodule

// File: tb/tb_acumulador_productos.sv
// Directed bench for acumulador_productos: default instance plus a DESPLAZA=2 instance.
module tb_acumulador_productos;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    acumulador_productos_if #(.ANCHO_PROD(16), .ANCHO_CUENTA(3)) bus1 ();
    acumulador_productos_if #(.ANCHO_PROD(16), .ANCHO_CUENTA(3)) bus2 ();

    acumulador_productos #(
        .ANCHO_PROD(16), .ANCHO_ACC(24), .N_MUESTRAS(4), .DESPLAZA(0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    acumulador_productos #(
        .ANCHO_PROD(16), .ANCHO_ACC(24), .N_MUESTRAS(4), .DESPLAZA(2)
    ) dut_d2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cargar(input logic signed [15:0] p);
        bus1.producto        = p;
        bus1.producto_valido = 1'b1;
        tick();
        bus1.producto_valido = 1'b0;
    endtask

    task automatic cargar2(input logic signed [15:0] p);
        bus2.producto        = p;
        bus2.producto_valido = 1'b1;
        tick();
        bus2.producto_valido = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus1.listo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_listo got=%b exp=0", bus1.listo);
        end
        n_checks++;
        if (bus1.salida_valida !== 1'b0 || bus1.saturado !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b%b exp=00",
                     bus1.salida_valida, bus1.saturado);
        end
        n_checks++;
        if (bus1.salida !== 16'sd0 || bus1.cuenta !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_vals salida=%0d cuenta=%0d exp=0 0",
                     bus1.salida, bus1.cuenta);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (bus1.listo !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_listo got=%b exp=1", bus1.listo);
        end
    endtask

    task automatic test_ventana();
        bus1.salida_tomada = 1'b1;
        cargar(16'sd11236);
        cargar(-16'sd9328);
        cargar(16'sd15876);
        cargar(16'sd100);
        n_checks++;
        if (bus1.salida_valida !== 1'b1 || bus1.salida !== 16'sd17884
            || bus1.saturado !== 1'b0) begin
            n_fail++;
            $display("FAIL ventana got v=%b s=%0d sat=%b exp v=1 s=17884 sat=0",
                     bus1.salida_valida, bus1.salida, bus1.saturado);
        end
        tick();
        bus1.salida_tomada = 1'b0;
        n_checks++;
        if (bus1.salida_valida !== 1'b0 || bus1.cuenta !== 3'd0
            || bus1.listo !== 1'b1) begin
            n_fail++;
            $display("FAIL entrega got v=%b c=%0d l=%b exp v=0 c=0 l=1",
                     bus1.salida_valida, bus1.cuenta, bus1.listo);
        end
        n_checks++;
        if (bus1.salida !== 16'sd17884) begin
            n_fail++;
            $display("FAIL salida_retenida got=%0d exp=17884", bus1.salida);
        end
    endtask

    task automatic test_saturacion();
        bus1.salida_tomada = 1'b0;
        for (int i = 0; i < 4; i++) cargar(-16'sd9328);
        n_checks++;
        if (bus1.salida !== -16'sd32768 || bus1.saturado !== 1'b1
            || bus1.salida_valida !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg got s=%0d sat=%b v=%b exp s=-32768 sat=1 v=1",
                     bus1.salida, bus1.saturado, bus1.salida_valida);
        end
        bus1.salida_tomada = 1'b1;
        tick();
        bus1.salida_tomada = 1'b0;
        for (int i = 0; i < 4; i++) cargar(16'sd15876);
        n_checks++;
        if (bus1.salida !== 16'sd32767 || bus1.saturado !== 1'b1
            || bus1.salida_valida !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos got s=%0d sat=%b v=%b exp s=32767 sat=1 v=1",
                     bus1.salida, bus1.saturado, bus1.salida_valida);
        end
        bus1.salida_tomada = 1'b1;
        tick();
        bus1.salida_tomada = 1'b0;
    endtask

    task automatic test_retencion();
        cargar(16'sd100);
        cargar(16'sd200);
        cargar(16'sd300);
        cargar(16'sd400);
        for (int i = 0; i < 5; i++) begin
            bus1.producto        = 16'(i * 7 + 3);
            bus1.producto_valido = 1'b1;
            tick();
            n_checks++;
            if (bus1.salida !== 16'sd1000 || bus1.salida_valida !== 1'b1
                || bus1.cuenta !== 3'd4 || bus1.listo !== 1'b0
                || bus1.saturado !== 1'b0) begin
                n_fail++;
                $display("FAIL retencion[%0d] s=%0d v=%b c=%0d l=%b sat=%b exp 1000 1 4 0 0",
                         i, bus1.salida, bus1.salida_valida, bus1.cuenta,
                         bus1.listo, bus1.saturado);
            end
        end
        bus1.producto      = 16'sd500;
        bus1.salida_tomada = 1'b1;
        tick();
        bus1.producto_valido = 1'b0;
        bus1.salida_tomada   = 1'b0;
        n_checks++;
        if (bus1.salida_valida !== 1'b0 || bus1.cuenta !== 3'd0) begin
            n_fail++;
            $display("FAIL handoff got v=%b c=%0d exp v=0 c=0",
                     bus1.salida_valida, bus1.cuenta);
        end
        tick();
        n_checks++;
        if (bus1.cuenta !== 3'd0 || bus1.listo !== 1'b1) begin
            n_fail++;
            $display("FAIL post_handoff got c=%0d l=%b exp c=0 l=1",
                     bus1.cuenta, bus1.listo);
        end
    endtask

    task automatic test_huecos();
        for (int v = 1; v <= 4; v++) begin
            cargar(16'(v));
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (bus1.cuenta !== 3'(v)) begin
                    n_fail++;
                    $display("FAIL huecos_cuenta[%0d.%0d] got=%0d exp=%0d",
                             v, k, bus1.cuenta, v);
                end
                if (k < 3) tick();
            end
        end
        n_checks++;
        if (bus1.salida !== 16'sd10 || bus1.salida_valida !== 1'b1) begin
            n_fail++;
            $display("FAIL huecos_salida got s=%0d v=%b exp s=10 v=1",
                     bus1.salida, bus1.salida_valida);
        end
        bus1.salida_tomada = 1'b1;
        tick();
        bus1.salida_tomada = 1'b0;
    endtask

    task automatic test_reset_medio();
        cargar(16'sd1000);
        cargar(16'sd2000);
        n_checks++;
        if (bus1.cuenta !== 3'd2) begin
            n_fail++;
            $display("FAIL medio_cuenta got=%0d exp=2", bus1.cuenta);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus1.cuenta !== 3'd0 || bus1.salida !== 16'sd0) begin
            n_fail++;
            $display("FAIL medio_reset got c=%0d s=%0d exp c=0 s=0",
                     bus1.cuenta, bus1.salida);
        end
        for (int i = 0; i < 4; i++) cargar(16'sd5);
        n_checks++;
        if (bus1.salida !== 16'sd20 || bus1.salida_valida !== 1'b1) begin
            n_fail++;
            $display("FAIL medio_salida got s=%0d v=%b exp s=20 v=1",
                     bus1.salida, bus1.salida_valida);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus1.salida_valida !== 1'b0 || bus1.salida !== 16'sd0
            || bus1.cuenta !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_entrega got v=%b s=%0d c=%0d exp 0 0 0",
                     bus1.salida_valida, bus1.salida, bus1.cuenta);
        end
        tick();
    endtask

    task automatic test_desplaza();
        logic signed [15:0] e_pos;
        logic signed [15:0] e_neg;
`ifdef ACUM_REDONDEO_EN
        e_pos = 16'sd2;
        e_neg = -16'sd1;
`else
        e_pos = 16'sd1;
        e_neg = -16'sd2;
`endif
        cargar2(16'sd1);
        cargar2(16'sd2);
        cargar2(16'sd3);
        cargar2(16'sd0);
        n_checks++;
        if (bus2.salida !== e_pos || bus2.salida_valida !== 1'b1) begin
            n_fail++;
            $display("FAIL desplaza_pos got s=%0d v=%b exp s=%0d v=1",
                     bus2.salida, bus2.salida_valida, e_pos);
        end
        bus2.salida_tomada = 1'b1;
        tick();
        bus2.salida_tomada = 1'b0;
        cargar2(-16'sd1);
        cargar2(-16'sd2);
        cargar2(-16'sd3);
        cargar2(16'sd0);
        n_checks++;
        if (bus2.salida !== e_neg || bus2.saturado !== 1'b0) begin
            n_fail++;
            $display("FAIL desplaza_neg got s=%0d sat=%b exp s=%0d sat=0",
                     bus2.salida, bus2.saturado, e_neg);
        end
        bus2.salida_tomada = 1'b1;
        tick();
        bus2.salida_tomada = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus1.producto        = '0;
        bus1.producto_valido = 1'b0;
        bus1.salida_tomada   = 1'b0;
        bus2.producto        = '0;
        bus2.producto_valido = 1'b0;
        bus2.salida_tomada   = 1'b0;
        test_reset();
        test_ventana();
        test_saturacion();
        test_retencion();
        test_huecos();
        test_reset_medio();
        test_desplaza();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
